terminal_input_fifo: RTL
========================

# terminal_input_fifo

Byte buffer between the serial receiver and the terminal stream automaton. It stores incoming bytes in a circular FIFO and presents them one at a time as `unicode`/`unicode_available`, paced by the automaton's `ready_n`. It also drives RTS flow control with hysteresis, so the host pauses during long operations such as screen clear and scroll. `unicode` is held stable between deliveries, because the automaton re-reads it in its multi-cycle write stages.

## Interface
- `DEPTH_LOG2`, 6: FIFO depth is 2^DEPTH_LOG2 bytes (64).
- `RTS_HIGH`, 48: occupancy at or above which `rts_n` deasserts (sender must stop).
- `RTS_LOW`, 16: occupancy at or below which `rts_n` reasserts.
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  received byte; valid only when `rx_available` is high.
- `rx_available`  in  1  one-cycle strobe from the serial receiver.
- `ready_n`  in  1  from the terminal stream automaton; 0 means it can accept a byte.
- `unicode`  out  8  byte delivered downstream; held until the next delivery.
- `unicode_available`  out  1  one-cycle delivery strobe.
- `rts_n`  out  1  flow control to host; 0 means send allowed.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `level`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.

## Operation
- **Storage**
  - 2^DEPTH_LOG2 × 8 register array.
  - Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `level` is a DEPTH_LOG2+1-bit counter.
- **Write**
  - On an edge with `rx_available`=1 and `level` < depth: store the byte at the write pointer and increment the pointer.
  - If `level` = depth at that edge, drop the byte and set `overflow`. This applies even if a read happens on the same edge.
- **Read state machine**, two states:
  - IDLE: if `level` > 0 and `ready_n`=0, register `unicode` from the read pointer, increment the read pointer, set `unicode_available`=1, go to HOLDOFF. Otherwise `unicode_available`=0 and stay in IDLE.
  - HOLDOFF: `unicode_available`=0, no read, unconditionally return to IDLE.
  - HOLDOFF exists because `ready_n` is registered downstream. The automaton's response to a byte is only visible two edges after the strobe, so no second byte may be issued on the edge immediately after a delivery.
- **Simultaneous read and write** (not full): `level` stays unchanged and both pointers advance.
- **Flow control**, registered:
  - `rts_n` goes to 1 when `level` ≥ RTS_HIGH.
  - `rts_n` goes to 0 when `level` ≤ RTS_LOW.
  - Between the two thresholds it holds its value.
  - Thresholds are compared against the `level` value before the edge.
- **`overflow`** is cleared only by reset.

## Timing
- **Reset values:** `unicode`=0x00, `unicode_available`=0, `rts_n`=1, `overflow`=0, `level`=0, both pointers 0, state IDLE.
- **First edge after reset:** `rts_n` goes to 0, since `level`=0 ≤ RTS_LOW.
- **Latency:** byte sampled on edge E0 into an empty FIFO, with `ready_n`=0 at E1 → `unicode_available` is high during the cycle after E1.
- **Maximum throughput:** one delivery every 2 cycles.
- **`unicode` stability:** changes only on an edge that sets `unicode_available`=1.
- **`ready_n`=1:** no delivery; the FIFO keeps filling.
- **Reset mid-operation:** contents are discarded and all outputs return to reset values on that edge. Any pending delivery is lost.
- **`level`** updates on the same edge as the pointer that changes it.

## Test plan
- **Single byte:** reset, `ready_n`=0, strobe 0x41 at edge E0 → `unicode`=0x41 with a one-cycle `unicode_available` after E1; `level` returns to 0.
- **Burst:** 10 bytes 0x30..0x39 on consecutive cycles, `ready_n`=0 → 10 strobes exactly 2 cycles apart, in order, with none missing or duplicated.
- **Backpressure:** `ready_n`=1, write 3 bytes → no strobe, `level`=3. Release `ready_n` → 3 deliveries. Re-raise `ready_n` for 20 cycles between deliveries → `unicode` holds the last value.
- **Flow control and overflow:** `ready_n`=1, write 66 bytes.
  - `rts_n`=1 from the edge after `level` reaches 48.
  - `level`=64 and `overflow`=1; bytes 65 and 66 are absent from the output.
  - Drain → `rts_n` returns to 0 on the edge after `level` reaches 16.
- **Wrap-around:** write and read 200 bytes in an interleaved pattern → byte order is preserved across pointer wrap.
- **Reset mid-operation:** reset with `level`=5 mid-burst → all outputs at reset values; no further deliveries until new writes arrive.

Source files
------------

// File: rtl/terminal_input_fifo_if.sv
// Byte path between the serial receiver, the input FIFO and the terminal stream automaton.
// The slave modport is the FIFO side; the master modport is the receiver/automaton side.
interface terminal_input_fifo_if #(
  parameter int DEPTH_LOG2 = 6
);
  logic [7:0]          rx_byte;
  logic                rx_available;
  logic                ready_n;
  logic [7:0]          unicode;
  logic                unicode_available;
  logic                rts_n;
  logic                overflow;
  logic [DEPTH_LOG2:0] level;

  modport master (
    output rx_byte, rx_available, ready_n,
    input  unicode, unicode_available, rts_n, overflow, level
  );

  modport slave (
    input  rx_byte, rx_available, ready_n,
    output unicode, unicode_available, rts_n, overflow, level
  );
endinterface

// File: rtl/terminal_input_fifo.sv
// Circular byte FIFO from the serial receiver to the terminal automaton, with RTS hysteresis.
// Delivery one edge after a byte is present with ready_n low; at most one byte every 2 cycles.
module terminal_input_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int RTS_HIGH   = 48,
  parameter int RTS_LOW    = 16
) (
  input logic                  clk,
  input logic                  reset,
  terminal_input_fifo_if.slave bus
);
  localparam int PTR_W = DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(RTS_HIGH);
  localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(RTS_LOW);

  typedef enum logic {
    IDLE,
    HOLDOFF
  } state_t;

  state_t           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       unicode_q;
  logic             avail_q;
  logic             rts_n_q, rts_n_d;
  logic             overflow_q;
  logic             full, wr_en, rd_en;

  always_comb begin
    full     = (level_q == LVL_FULL);
    wr_en    = bus.rx_available && !full;
    rd_en    = (state_q == IDLE) && (level_q != '0) && !bus.ready_n;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    // Hysteresis works on the pre-edge occupancy; between thresholds rts_n holds.
    rts_n_d  = rts_n_q;
    if (level_q >= LVL_HIGH) begin
      rts_n_d = 1'b1;
    end else if (level_q <= LVL_LOW) begin
      rts_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= bus.rx_byte;
    end
  end

  // HOLDOFF covers the automaton's registered ready_n: it cannot react to a
  // delivery until two edges after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      unicode_q  <= 8'h00;
      avail_q    <= 1'b0;
      rts_n_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rts_n_q  <= rts_n_d;
      if (bus.rx_available && full) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (rd_en) begin
            unicode_q <= mem_q[rd_ptr_q];
            avail_q   <= 1'b1;
            state_q   <= HOLDOFF;
          end else begin
            avail_q   <= 1'b0;
          end
        end
        HOLDOFF: begin
          avail_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.unicode           = unicode_q;
  assign bus.unicode_available = avail_q;
  assign bus.rts_n             = rts_n_q;
  assign bus.overflow          = overflow_q;
  assign bus.level             = level_q;
endmodule
